// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared parity encodings, frame FSM states and data-length limit for the UART RX path
package uart_rx_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int MIN_DATA_LEN = 5;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE
  } frame_state_e;

  // data_xor is the XOR of all received data bits.
  function automatic logic exp_parity(input logic [1:0] typ, input logic data_xor);
    case (typ)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_err_counter.sv
// rtl/uart_err_counter.sv - saturating error counter; clear wins over increment
module uart_err_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_checker.sv
// rtl/uart_rx_frame_checker.sv - UART RX deserialiser with parity/stop checking
// Optional saturating error counters are built only when UART_RX_ERR_CNT_EN is defined.
module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8,
  localparam int LEN_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic                  START_DET,
  input  logic                  BIT_STRB,
  input  logic                  SAMPLED_BIT,
  input  logic                  CNT_CLR,
  output logic                  BUSY,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  FRAME_DONE,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic [CNT_WIDTH-1:0]  PAR_ERR_CNT,
  output logic [CNT_WIDTH-1:0]  STP_ERR_CNT
);

  localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_DATA_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(DATA_WIDTH);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  frame_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_typ_q, par_typ_d;
  logic                  run_par_q, run_par_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_pulse_q, par_pulse_d;
  logic                  stp_pulse_q, stp_pulse_d;
  logic [LEN_W-1:0]      len_clamped;

  assign len_clamped = ((DATA_LEN < MIN_LEN) || (DATA_LEN > MAX_LEN)) ? MAX_LEN : DATA_LEN;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    len_d        = len_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    run_par_d    = run_par_q;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    stop_idx_d   = stop_idx_q;
    p_data_d     = p_data_q;
    frame_done_d = 1'b0;
    data_valid_d = 1'b0;
    par_pulse_d  = 1'b0;
    stp_pulse_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START_DET) begin
          state_d    = DATA;
          len_d      = len_clamped;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          shift_d    = '0;
          idx_d      = '0;
          run_par_d  = 1'b0;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
          stop_idx_d = 1'b0;
        end
      end
      DATA: begin
        if (BIT_STRB) begin
          shift_d   = shift_q | (DATA_WIDTH'(SAMPLED_BIT) << idx_q);
          run_par_d = run_par_q ^ SAMPLED_BIT;
          idx_d     = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (BIT_STRB) begin
          par_err_d = (SAMPLED_BIT != exp_parity(par_typ_q, run_par_q));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (BIT_STRB) begin
          stp_err_d  = stp_err_q | ~SAMPLED_BIT;
          stop_idx_d = stop_idx_q + 1'b1;
          // Completion outputs are registered so they appear during DONE.
          if (stop_idx_q == STOP_LAST) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
            par_pulse_d  = par_err_q;
            stp_pulse_d  = stp_err_d;
            data_valid_d = ~(par_err_q | stp_err_d);
            p_data_d     = shift_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 2'b00;
      run_par_q    <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      stop_idx_q   <= 1'b0;
      busy_q       <= 1'b0;
      p_data_q     <= '0;
      frame_done_q <= 1'b0;
      data_valid_q <= 1'b0;
      par_pulse_q  <= 1'b0;
      stp_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      run_par_q    <= run_par_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      stop_idx_q   <= stop_idx_d;
      busy_q       <= busy_d;
      p_data_q     <= p_data_d;
      frame_done_q <= frame_done_d;
      data_valid_q <= data_valid_d;
      par_pulse_q  <= par_pulse_d;
      stp_pulse_q  <= stp_pulse_d;
    end
  end

  assign BUSY       = busy_q;
  assign P_DATA     = p_data_q;
  assign FRAME_DONE = frame_done_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_pulse_q;
  assign STP_ERR    = stp_pulse_q;

`ifdef UART_RX_ERR_CNT_EN
  uart_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (CNT_CLR),
    .inc (par_pulse_q),
    .cnt (PAR_ERR_CNT)
  );

  uart_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (CNT_CLR),
    .inc (stp_pulse_q),
    .cnt (STP_ERR_CNT)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign PAR_ERR_CNT    = '0;
  assign STP_ERR_CNT    = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb/tb_uart_rx_frame_checker.sv - frame-level model and directed frames for uart_rx_frame_checker
module tb_uart_rx_frame_checker;

  localparam int LEN_W = 4;
`ifdef UART_RX_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             PAR_EN = 1'b0;
  logic [1:0]       PAR_TYP = 2'b00;
  logic [LEN_W-1:0] DATA_LEN = 4'd8;
  logic             START_DET = 1'b0;
  logic             BIT_STRB = 1'b0;
  logic             SAMPLED_BIT = 1'b0;
  logic             CNT_CLR = 1'b0;
  logic             BUSY, FRAME_DONE, DATA_VALID, PAR_ERR, STP_ERR;
  logic [7:0]       P_DATA, PAR_ERR_CNT, STP_ERR_CNT;

  uart_rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .DATA_LEN    (DATA_LEN),
    .START_DET   (START_DET),
    .BIT_STRB    (BIT_STRB),
    .SAMPLED_BIT (SAMPLED_BIT),
    .CNT_CLR     (CNT_CLR),
    .BUSY        (BUSY),
    .P_DATA      (P_DATA),
    .FRAME_DONE  (FRAME_DONE),
    .DATA_VALID  (DATA_VALID),
    .PAR_ERR     (PAR_ERR),
    .STP_ERR     (STP_ERR),
    .PAR_ERR_CNT (PAR_ERR_CNT),
    .STP_ERR_CNT (STP_ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         done;
    logic [7:0] pdata;
    bit         perr;
    bit         serr;
  } exp_frame_t;

  exp_frame_t q[$];
  int         cyc = 0;
  int         open_start = -1;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_pdata = 8'h00;
  logic [7:0] m_pcnt = 8'h00;
  logic [7:0] m_scnt = 8'h00;
  bit         pulse;
  bit         exp_busy;
  exp_frame_t cur;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame-level expectations.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("rst_busy", BUSY, 0);
      chk("rst_done", FRAME_DONE, 0);
      chk("rst_valid", DATA_VALID, 0);
      chk("rst_perr", PAR_ERR, 0);
      chk("rst_serr", STP_ERR, 0);
      chk("rst_pdata", P_DATA, 0);
      chk("rst_pcnt", PAR_ERR_CNT, 0);
      chk("rst_scnt", STP_ERR_CNT, 0);
      m_pdata = 8'h00;
      m_pcnt  = 8'h00;
      m_scnt  = 8'h00;
    end else begin
      pulse = (q.size() > 0) && (q[0].done == cyc);
      exp_busy = ((open_start >= 0) && (cyc >= open_start)) || ((q.size() > 0) && (cyc <= q[0].done));
      if (pulse) begin
        cur = q.pop_front();
        m_pdata = cur.pdata;
      end else begin
        cur = '{done: 0, pdata: 8'h00, perr: 1'b0, serr: 1'b0};
      end
      chk("busy", BUSY, exp_busy);
      chk("frame_done", FRAME_DONE, pulse);
      chk("data_valid", DATA_VALID, pulse && !cur.perr && !cur.serr);
      chk("par_err", PAR_ERR, pulse && cur.perr);
      chk("stp_err", STP_ERR, pulse && cur.serr);
      chk("p_data", P_DATA, m_pdata);
      chk("par_err_cnt", PAR_ERR_CNT, m_pcnt);
      chk("stp_err_cnt", STP_ERR_CNT, m_scnt);
      if (CNT_ON && pulse && cur.perr && m_pcnt != 8'hFF) m_pcnt++;
      if (CNT_ON && pulse && cur.serr && m_scnt != 8'hFF) m_scnt++;
      if (CNT_CLR) begin
        m_pcnt = 8'h00;
        m_scnt = 8'h00;
      end
    end
  end

  task automatic drive(input bit st, input bit strb, input bit b);
    @(posedge CLK);
    #1;
    START_DET   = st;
    BIT_STRB    = strb;
    SAMPLED_BIT = b;
    CNT_CLR     = 1'b0;
  endtask

  task automatic scramble_cfg();
    DATA_LEN = 4'($urandom_range(0, 15));
    PAR_EN   = 1'($urandom_range(0, 1));
    PAR_TYP  = 2'($urandom_range(0, 3));
  endtask

  // Returns during the cycle in which the completion pulses are expected.
  task automatic send_frame(input int len, input bit pen, input bit [1:0] ptyp, input bit [7:0] data,
                            input bit pbit, input bit s0, input bit s1, input bit clr_at_done);
    int         eff;
    bit [7:0]   d;
    bit         ep;
    exp_frame_t f;
    eff = (len < 5 || len > 8) ? 8 : len;
    d   = data & (8'hFF >> (8 - eff));
    case (ptyp)
      2'b00:   ep = ($countones(d) % 2) == 1;
      2'b01:   ep = ($countones(d) % 2) == 0;
      2'b10:   ep = 1'b1;
      default: ep = 1'b0;
    endcase
    drive(0, 1, 1);
    drive(1, 1, 1);
    DATA_LEN   = 4'(len);
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    open_start = cyc + 1;
    for (int i = 0; i < eff; i++) begin
      drive(i == 3, 0, 0);
      scramble_cfg();
      drive(0, 1, data[i]);
    end
    if (pen) begin
      drive(0, 0, 0);
      drive(0, 1, pbit);
    end
    drive(0, 1, s0);
    drive(0, 1, s1);
    f.done  = cyc + 1;
    f.pdata = d;
    f.perr  = pen && (pbit != ep);
    f.serr  = !s0 || !s1;
    q.push_back(f);
    open_start = -1;
    drive(0, 1, 0);
    CNT_CLR = clr_at_done;
  endtask

  initial begin
    repeat (3) drive(0, 0, 0);
    RST = 1'b1;
    drive(0, 0, 0);
    chk("lit_reset_pdata", P_DATA, 8'h00);

    send_frame(8, 1, 2'b00, 8'hA5, 0, 1, 1, 0);
    chk("lit_even_done", FRAME_DONE, 1);
    chk("lit_even_valid", DATA_VALID, 1);
    chk("lit_even_perr", PAR_ERR, 0);
    chk("lit_even_pdata", P_DATA, 8'hA5);

    send_frame(8, 1, 2'b01, 8'h03, 0, 1, 1, 0);
    chk("lit_odd_perr", PAR_ERR, 1);
    chk("lit_odd_valid", DATA_VALID, 0);
    chk("lit_odd_pdata", P_DATA, 8'h03);
    drive(0, 0, 0);
    chk("lit_odd_cnt", PAR_ERR_CNT, CNT_ON ? 1 : 0);

    send_frame(5, 0, 2'b00, 8'hFF, 0, 1, 0, 0);
    chk("lit_len5_serr", STP_ERR, 1);
    chk("lit_len5_pdata", P_DATA, 8'h1F);
    drive(0, 0, 0);
    chk("lit_len5_cnt", STP_ERR_CNT, CNT_ON ? 1 : 0);

    send_frame(8, 1, 2'b10, 8'h00, 1, 1, 1, 0);
    chk("lit_mark_perr", PAR_ERR, 0);
    send_frame(8, 1, 2'b11, 8'h00, 1, 1, 1, 0);
    chk("lit_space_perr", PAR_ERR, 1);

    send_frame(3, 0, 2'b00, 8'hC3, 0, 1, 1, 0);
    chk("lit_clamp_lo", P_DATA, 8'hC3);
    send_frame(15, 0, 2'b00, 8'h96, 0, 1, 1, 0);
    send_frame(6, 1, 2'b00, 8'hFF, 0, 1, 1, 0);
    chk("lit_len6_pdata", P_DATA, 8'h3F);

    drive(1, 0, 0);
    DATA_LEN   = 4'd8;
    PAR_EN     = 1'b1;
    PAR_TYP    = 2'b00;
    open_start = cyc + 1;
    drive(0, 1, 1);
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(0, 1, 1);
    @(posedge CLK);
    #1;
    RST        = 1'b0;
    BIT_STRB   = 1'b0;
    open_start = -1;
    q.delete();
    drive(0, 0, 0);
    chk("lit_rst_busy", BUSY, 0);
    chk("lit_rst_done", FRAME_DONE, 0);
    drive(0, 0, 0);
    RST = 1'b1;
    drive(0, 0, 0);

    send_frame(8, 1, 2'b00, 8'h5A, 0, 1, 1, 0);
    chk("lit_after_rst_pdata", P_DATA, 8'h5A);
    chk("lit_after_rst_valid", DATA_VALID, 1);

    for (int n = 0; n < 300; n++) send_frame(8, 1, 2'b00, 8'h01, 0, 1, 1, 0);
    drive(0, 0, 0);
    chk("lit_sat_cnt", PAR_ERR_CNT, CNT_ON ? 255 : 0);
    send_frame(8, 1, 2'b00, 8'h01, 0, 1, 1, 1);
    drive(0, 0, 0);
    chk("lit_clr_prio", PAR_ERR_CNT, 0);
    repeat (3) drive(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
Parametrised UART RX frame checker. It consumes mid-bit sampled bits from the RX sampler/FSM and deserialises the data LSB first. Parity (even/odd/mark/space) is computed on the fly, and parity and stop bits are checked. It raises one-cycle completion/error pulses and maintains optional saturating error counters. It sits between the edge/bit sampler and the RX output register, and replaces separate deserialiser, parity and stop-check blocks.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame; width of P_DATA.
STOP_BITS, 1, number of stop bits checked (1 or 2).
CNT_WIDTH, 8, width of each error counter.
LEN_W, $clog2(DATA_WIDTH+1), width of DATA_LEN (derived localparam, not overridden).

Ports:
CLK  in  1  clock.
RST  in  1  asynchronous, active-low reset.
PAR_EN  in  1  1 = frame carries a parity bit.
PAR_TYP  in  2  00 even, 01 odd, 10 mark, 11 space.
DATA_LEN  in  LEN_W  data bits per frame; legal 5..DATA_WIDTH; out-of-range values are clamped to DATA_WIDTH.
START_DET  in  1  one-cycle pulse; start bit validated upstream.
BIT_STRB  in  1  one-cycle pulse; SAMPLED_BIT is valid.
SAMPLED_BIT  in  1  majority-sampled line value.
CNT_CLR  in  1  synchronous clear of error counters.
BUSY  out  1  frame in progress.
P_DATA  out  DATA_WIDTH  received data, zero-extended above DATA_LEN.
FRAME_DONE  out  1  one-cycle pulse at end of every frame.
DATA_VALID  out  1  one-cycle pulse; frame complete and error-free.
PAR_ERR  out  1  one-cycle pulse with FRAME_DONE.
STP_ERR  out  1  one-cycle pulse with FRAME_DONE.
PAR_ERR_CNT  out  CNT_WIDTH  saturating parity-error count.
STP_ERR_CNT  out  CNT_WIDTH  saturating stop-error count.

Behaviour:
- Reset state:
  - FSM = IDLE.
  - All outputs 0, including P_DATA and both counters.
  - Shift register, bit index and running parity cleared.
- FSM states: IDLE, DATA, PARITY, STOP, DONE.
  - IDLE -> DATA on START_DET. PAR_EN, PAR_TYP and DATA_LEN are latched at this point; input changes mid-frame have no effect.
  - DATA: each BIT_STRB writes SAMPLED_BIT to bit[idx], XORs it into the running parity and increments idx.
    - After DATA_LEN bits: go to PARITY if the latched PAR_EN is 1, otherwise go to STOP.
  - PARITY: one BIT_STRB captures the received parity bit. Expected value:
    - even: ^data
    - odd: ~^data
    - mark: 1
    - space: 0
    - par_err_q = received != expected.
  - STOP: STOP_BITS strobes. stp_err_q is set if any stop bit samples 0. Go to DONE after the last stop strobe.
  - DONE: lasts one cycle.
    - FRAME_DONE = 1; PAR_ERR and STP_ERR driven from the q flags.
    - DATA_VALID = ~(par_err_q | stp_err_q).
    - P_DATA updated from the shift register.
    - Then go to IDLE.
  - Latency: the completion pulses occur exactly 1 cycle after the final stop-bit strobe.
- BUSY = 1 in DATA, PARITY, STOP and DONE.
- P_DATA holds its value between frames. It updates only in DONE, including on error frames.
- Simultaneous events:
  - START_DET and BIT_STRB in the same cycle in IDLE: the start is accepted and the strobe is ignored.
  - START_DET while BUSY: ignored.
  - BIT_STRB in IDLE or DONE: ignored.
- Counters:
  - Each increments by 1 on its error pulse and saturates at all-ones.
  - CNT_CLR has priority over an increment in the same cycle.
- Reset asserted mid-frame: immediate return to IDLE. No FRAME_DONE is produced. Counters are cleared.

Optional Feature:
UART_RX_ERR_CNT_EN
- Defined: the PAR_ERR_CNT and STP_ERR_CNT counters are implemented as described under Behaviour.
- Undefined: no counter flops are built; both outputs are tied to 0 and CNT_CLR is ignored. Ports are identical in both builds.

Decomposition:
- Shared package uart_rx_pkg:
  - Parity type encodings PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE.
  - FSM state typedef frame_state_e.
  - Localparam MIN_DATA_LEN = 5.
- One natural sub-module: uart_err_counter (saturating counter with clear and increment), instantiated twice under the macro.

Test Plan:
- Even parity, DATA_LEN=8: data 0xA5, parity 0, stop 1 -> P_DATA=0xA5, DATA_VALID=1, PAR_ERR=0, 1 cycle after stop strobe.
- Odd parity: data 0x03 with parity bit 0 -> PAR_ERR=1, DATA_VALID=0, FRAME_DONE=1, P_DATA=0x03, PAR_ERR_CNT=1.
- DATA_LEN=5, PAR_EN=0, STOP_BITS=2: data 0x1F, stop bits 1 then 0 -> STP_ERR=1, P_DATA=0x1F, STP_ERR_CNT=1.
- Mark parity: data 0x00 with parity bit 1 -> PAR_ERR=0; repeat with space parity and parity bit 1 -> PAR_ERR=1.
- START_DET pulsed mid-frame, then RST low after the 3rd data bit -> no FRAME_DONE, BUSY=0, all outputs 0; the next clean frame 0x5A is received correctly.
- Macro defined: 300 consecutive parity-error frames with CNT_WIDTH=8 -> PAR_ERR_CNT saturates at 255; CNT_CLR coincident with an error -> count = 0.
